// File: rtl/prom_pkg.sv
// Shared types and defaults for the PROM image writer.
package prom_pkg;

  localparam int unsigned DEPTH_DEF  = 256;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W     = 8;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WR_LO,
    WR_HI,
    CSUM,
    VERIFY,
    DRAIN,
    DONE,
    ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_CSUM     = 2'b01,
    ERR_READBACK = 2'b10
  } err_code_e;

endpackage

// File: rtl/prom_writer.sv
// Loads a byte stream into a nibble-wide PROM image, checks the stream checksum,
// then reads the whole image back and checks it against the same checksum.
module prom_writer
  import prom_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int unsigned BYTE_W = 2 * DATA_W;
  localparam int unsigned IDX_W  = (DEPTH > 2) ? $clog2(DEPTH / 2) : 1;

  state_e              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [BYTE_W-1:0]   byte_q, byte_n;
  logic [BYTE_W-1:0]   sum_q, sum_n;
  logic [BYTE_W-1:0]   exp_q, exp_n;
  logic [BYTE_W-1:0]   vsum_q, vsum_n;
  logic [BYTE_W-1:0]   vsum_add;
  logic [DATA_W-1:0]   lo_q, lo_n;
  logic                pend_q, pend_n;
  logic                pend_odd_q, pend_odd_n;
  logic                mem_we_n, mem_re_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic                busy_n, done_n, err_n;
  err_code_e           err_code_q, err_code_n;

  assign in_ready = (state == LOAD) || (state == CSUM);
  assign err_code = err_code_q;

  // State and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      byte_q     <= '0;
      sum_q      <= '0;
      exp_q      <= '0;
      vsum_q     <= '0;
      lo_q       <= '0;
      pend_q     <= 1'b0;
      pend_odd_q <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      byte_q     <= byte_n;
      sum_q      <= sum_n;
      exp_q      <= exp_n;
      vsum_q     <= vsum_n;
      lo_q       <= lo_n;
      pend_q     <= pend_n;
      pend_odd_q <= pend_odd_n;
      mem_we     <= mem_we_n;
      mem_re     <= mem_re_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
      err_code_q <= err_code_n;
    end
  end

  // Next state, datapath and outputs.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    byte_n      = byte_q;
    sum_n       = sum_q;
    exp_n       = exp_q;
    vsum_n      = vsum_q;
    lo_n        = lo_q;
    pend_n      = 1'b0;
    pend_odd_n  = 1'b0;
    mem_we_n    = 1'b0;
    mem_re_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    done_n      = done;
    err_n       = err;
    err_code_n  = err_code_q;
    vsum_add    = vsum_q + {mem_rdata, lo_q};

    // Read data returns one cycle after the strobe; odd addresses close a byte.
    if (pend_q) begin
      if (pend_odd_q) vsum_n = vsum_add;
      else            lo_n   = mem_rdata;
    end

    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_n    = LOAD;
          idx_n      = '0;
          sum_n      = '0;
          vsum_n     = '0;
          done_n     = 1'b0;
          err_n      = 1'b0;
          err_code_n = ERR_NONE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          byte_n      = in_data;
          sum_n       = sum_q + in_data;
          state_n     = WR_LO;
          mem_we_n    = 1'b1;
          mem_addr_n  = ADDR_W'({idx, 1'b0});
          mem_wdata_n = in_data[DATA_W-1:0];
        end
      end
      WR_LO: begin
        state_n     = WR_HI;
        mem_we_n    = 1'b1;
        mem_addr_n  = ADDR_W'({idx, 1'b1});
        mem_wdata_n = byte_q[BYTE_W-1:DATA_W];
      end
      WR_HI: begin
        idx_n   = idx + IDX_W'(1);
        state_n = (idx == IDX_W'(DEPTH / 2 - 1)) ? CSUM : LOAD;
      end
      CSUM: begin
        if (in_valid) begin
          exp_n = in_data;
          if (in_data != sum_q) begin
            state_n    = ERROR;
            err_n      = 1'b1;
            err_code_n = ERR_CSUM;
          end else begin
            state_n    = VERIFY;
            mem_re_n   = 1'b1;
            mem_addr_n = '0;
          end
        end
      end
      VERIFY: begin
        pend_n     = 1'b1;
        pend_odd_n = mem_addr[0];
        if (mem_addr == ADDR_W'(DEPTH - 1)) begin
          state_n = DRAIN;
        end else begin
          mem_re_n   = 1'b1;
          mem_addr_n = mem_addr + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // The final odd-address nibble arrives this cycle, so compare the live sum.
        if (vsum_add == exp_q) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n    = ERROR;
          err_n      = 1'b1;
          err_code_n = ERR_READBACK;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = !(state_n inside {IDLE, DONE, ERROR});
  end

endmodule

// File: doc/prom_writer.md
PROM_WRITER -- requirements
Module: prom_writer

Interface
REQ-001 Parameter DEPTH, default 256, number of 4-bit PROM locations; must be even.
REQ-002 Parameter DATA_W, default 4, PROM word width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 in_valid  input  1  source byte valid.
REQ-007 in_data  input  8  source byte: low nibble goes to even address, high nibble to the next odd address.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 mem_we  output  1  PROM image write strobe.
REQ-010 mem_re  output  1  PROM image read strobe.
REQ-011 mem_addr  output  8  PROM image address.
REQ-012 mem_wdata  output  4  PROM image write data.
REQ-013 mem_rdata  input  4  PROM image read data, valid one cycle after mem_re.
REQ-014 busy  output  1  high in every state except IDLE, DONE and ERROR.
REQ-015 done  output  1  load and readback succeeded.
REQ-016 err  output  1  load failed.
REQ-017 err_code  output  2  00 none, 01 stream checksum mismatch, 10 readback mismatch.

Function
REQ-018 States: IDLE, LOAD, WR_LO, WR_HI, CSUM, VERIFY, DRAIN, DONE, ERROR.
REQ-019 All outputs are registered except in_ready, which is decoded from the state (high only in LOAD and CSUM).
REQ-020 IDLE/DONE/ERROR + start -> LOAD: clear byte index, sum and verify sum, done, err and err_code. start is ignored while busy.
REQ-021 LOAD + (in_valid & in_ready) -> latch the byte, sum <= sum + byte (mod 256), then go to WR_LO.
REQ-022 WR_LO drives mem_we=1, mem_addr=2*idx, mem_wdata=byte[3:0], then goes to WR_HI.
REQ-023 WR_HI drives mem_we=1, mem_addr=2*idx+1, mem_wdata=byte[7:4], then increments idx; it goes to CSUM when idx reaches DEPTH/2, otherwise to LOAD.
REQ-024 Each data byte takes at least 3 cycles to accept and write; in_valid with in_ready low has no effect.
REQ-025 CSUM + handshake: the received byte is stored as expected. If expected != sum, go to ERROR with code 01; otherwise go to VERIFY with address 0.
REQ-026 VERIFY issues mem_re=1 with mem_addr=k on cycle k, for k = 0..DEPTH-1, back-to-back.
REQ-027 Readback data for address k is sampled one cycle later. Even addresses are held as the low nibble; each odd address completes byte {hi,lo}, which is added mod 256 to the verify sum.
REQ-028 DRAIN: one cycle that captures the last nibble, then compares. Verify sum == expected goes to DONE, otherwise to ERROR with code 10.
REQ-029 DONE holds done=1 and ERROR holds err=1 plus err_code, until start or reset.
REQ-030 mem_we and mem_re are never high in the same cycle; both are 0 outside their states.
REQ-031 Address arithmetic is 8-bit with no wrap beyond DEPTH-1; idx is 7 bits.
REQ-032 Latency from the checksum handshake to done or err (code 10) is exactly DEPTH+2 cycles.

Reset
REQ-033 Reset asserted in any state: state=IDLE; in_ready, mem_we, mem_re, busy, done and err are 0; err_code=00; mem_addr, mem_wdata, idx and both sums are 0.
REQ-034 Reset mid-load leaves the PROM image contents undefined; a new start fully rewrites it.

Structure
REQ-035 Package prom_pkg holds the state enum, the err_code enum and the DEPTH/DATA_W defaults.
REQ-036 Single module with no sub-module; the sum accumulators are inline.

Verification
REQ-037 The bench uses a 256x4 synchronous RAM model with one-cycle read latency on the mem_* ports.
REQ-038 Load bytes 0x10..0x8F plus checksum 0xC0 -> RAM[0]=0, RAM[1]=1, RAM[255]=8; done=1 and err_code=00 exactly 258 cycles after the checksum handshake.
REQ-039 Same data with checksum 0xC1 -> err=1 and err_code=01 one cycle after the checksum handshake; mem_re never asserted.
REQ-040 Valid load while the RAM model forces address 37 to read 0xF -> err=1, err_code=10; done stays 0.
REQ-041 Assert reset after 40 bytes, then restart with all bytes 0xA5 and checksum 0x80 -> done=1; every RAM location reads 5 (even) or A (odd).
REQ-042 Random in_valid gaps, start pulsed mid-load, in_valid held high in VERIFY -> start and extra bytes are ignored; result is identical to the gap-free run.
